// File: rtl/lsu_pkg.sv
// Shared encodings, state type and request payload for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_W,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  // Fields of an accepted request still needed after the accept edge.
  typedef struct packed {
    logic [1:0]        size;
    logic              sgn;
    logic [1:0]        offset;
    logic [HALF_W-1:0] wdata;
  } req_t;

  // Size/offset combinations that cannot map onto one aligned word access.
  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane
// merge of store data into an existing word for read-modify-write stores.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [HALF_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [7:0]        lane_b;
  logic [HALF_W-1:0] lane_h;

  assign lane_b = word[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data_c = word;
    case (size)
      SZ_BYTE: load_data_c = sgn ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      SZ_HALF: load_data_c = sgn ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: load_data_c = word;
    endcase
  end

  // Only sub-word stores merge; a word store bypasses this path entirely.
  always_comb begin
    merge_data_c = word;
    case (size)
      SZ_BYTE: merge_data_c[{offset, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merge_data_c[{offset[1], 4'b0000} +: 16] = wdata;
      default: merge_data_c = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Bridges byte-addressed MEM-stage loads/stores onto a word-addressed data
// memory, using read-modify-write for byte and halfword stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 2010,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_readData
);

  state_t            state;
  req_t              req_q;
  logic              mem_write_q;
  logic              mem_read_q;
  logic [ADDR_W-1:0] word_idx_c;
  logic              acc_err_c;
  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] merge_data_c;

  assign word_idx_c = req_addr >> 2;
  assign acc_err_c  = bad_align(req_size, req_addr[1:0]) || (word_idx_c >= ADDR_W'(DEPTH));

  // Reset must suppress a commit on the very edge it is sampled.
  assign mem_write = mem_write_q & ~rst;
  assign mem_read  = mem_read_q & ~rst;

  byte_lane_unit u_lanes (
    .word         (mem_readData),
    .offset       (req_q.offset),
    .size         (req_q.size),
    .sgn          (req_q.sgn),
    .wdata        (req_q.wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_q         <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q       <= '{size: req_size, sgn: req_signed, offset: req_addr[1:0],
                             wdata: req_wdata[HALF_W-1:0]};
            mem_address <= 32'(word_idx_c);
            req_ready   <= 1'b0;
            if (acc_err_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!req_write) begin
              state      <= LOAD;
              mem_read_q <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state         <= STORE_W;
              mem_write_q   <= 1'b1;
              mem_writeData <= req_wdata;
            end else begin
              state      <= RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          mem_read_q <= 1'b0;
          rsp_rdata  <= load_data_c;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        STORE_W: begin
          mem_write_q <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        // The write-data register doubles as the merge register.
        RMW_RD: begin
          mem_read_q    <= 1'b0;
          mem_writeData <= merge_data_c;
          mem_write_q   <= 1'b1;
          state         <= RMW_WR;
        end
        RMW_WR: begin
          mem_write_q <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready   <= 1'b1;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned DEPTH  = 2010;
  localparam int unsigned ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_readData;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_address  (mem_address),
    .mem_writeData(mem_writeData),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_readData (mem_readData)
  );

  // Word memory: preloaded during the first clocks, then written by the DUT.
  logic [31:0] mem [0:DEPTH-1];
  bit preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem[3]    <= 32'h1122_3344;
      mem[5]    <= 32'h8899_AABB;
      mem[2009] <= 32'h7654_3210;
    end else if (mem_write && mem_address < DEPTH) begin
      mem[11'(mem_address)] <= mem_writeData;
    end
  end

  assign mem_readData = (mem_address < DEPTH) ? mem[11'(mem_address)] : 32'hDEAD_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          write;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit w, input logic [1:0] sz, input bit s, input logic [31:0] a,
                              input logic [31:0] wd, input bit e, input logic [31:0] rd, input int l);
    vec_t v;
    v.write = w; v.size = sz; v.sgn = s; v.addr = a; v.wdata = wd;
    v.err = e; v.rdata = rd; v.lat = l;
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.ready_timeout: req_ready stuck at 0", tag);
    end
  endtask

  task automatic drive(input bit w, input logic [1:0] sz, input bit s, input logic [31:0] a,
                       input logic [31:0] wd);
    req_write = w; req_size = sz; req_signed = s; req_addr = a; req_wdata = wd;
  endtask

  task automatic do_req(input vec_t v, input int idx);
    int    cyc, wr_n, rd_n, wr_cyc;
    bit    seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_ready(tag);
    drive(v.write, v.size, v.sgn, v.addr, v.wdata);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 0; wr_n = 0; rd_n = 0; wr_cyc = 0; seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_write) begin
        wr_n++;
        if (wr_cyc == 0) wr_cyc = cyc;
      end
      if (mem_read) rd_n++;
      if (mem_write || mem_read) chk({tag, ".mem_address"}, mem_address, v.addr >> 2);
      if (rsp_valid) seen = 1'b1;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(v.lat));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.err));
    chk({tag, ".rsp_rdata"}, rsp_rdata, v.rdata);
    chk({tag, ".writes"}, 32'(wr_n), (v.write && !v.err) ? 32'd1 : 32'd0);
    chk({tag, ".reads"}, 32'(rd_n), (!v.err && (!v.write || v.size != SZ_WORD)) ? 32'd1 : 32'd0);
    if (v.write && !v.err)
      chk({tag, ".write_cycle"}, 32'(wr_cyc), (v.size == SZ_WORD) ? 32'd1 : 32'd2);
    @(negedge clk);
    chk({tag, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    bit          write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } sreq_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sreq_t s[5];
    int    acc_i, rsp_i, extra;
    bit    pend;

    rst = 1'b1;
    req_valid = 1'b0;
    drive(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    chk("reset.mem_write", 32'(mem_write), 32'd0);
    chk("reset.mem_read", 32'(mem_read), 32'd0);
    chk("reset.mem_address", mem_address, 32'h0);
    chk("reset.mem_writeData", mem_writeData, 32'h0);
    rst = 1'b0;

    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h16,   32'h0,        0, 32'hFFFF_FF99, 2));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h16,   32'h0,        0, 32'h0000_8899, 2));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h14,   32'h0,        0, 32'h8899_AABB, 2));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h15,   32'h0,        0, 32'h0000_00AA, 2));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h14,   32'h0,        0, 32'hFFFF_AABB, 2));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h17,   32'h0,        0, 32'hFFFF_FF88, 2));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h0D,   32'h1234_56EE, 0, 32'hFFFF_FF88, 3));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h0C,   32'h0,        0, 32'h1122_EE44, 2));
    vecs.push_back(mk(1, SZ_HALF, 0, 32'h0F,   32'hABCD,     1, 32'h1122_EE44, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h1F68, 32'h0,        1, 32'h1122_EE44, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h0C,   32'h0,        0, 32'h1122_EE44, 2));
    vecs.push_back(mk(1, SZ_HALF, 0, 32'h0E,   32'hFFFF_BEEF, 0, 32'h1122_EE44, 3));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h20,   32'hDEAD_BEEF, 0, 32'h1122_EE44, 2));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h20,   32'h0,        0, 32'hDEAD_BEEF, 2));
    vecs.push_back(mk(0, 2'b11,   0, 32'h20,   32'h0,        1, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h22,   32'h0,        1, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h1F66, 32'h0,        0, 32'h0000_7654, 2));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h1F64, 32'h0,        0, 32'h0000_3210, 2));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h0C,   32'h0,        0, 32'h0000_3210, 3));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h0F,   32'h5A,       0, 32'h0000_3210, 3));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h0C,   32'h0,        0, 32'h5AEF_EE00, 2));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h15,   32'h0,        1, 32'h5AEF_EE00, 1));
    vecs.push_back(mk(1, SZ_HALF, 0, 32'h0D,   32'h1111,     1, 32'h5AEF_EE00, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h0C,   32'h0,        0, 32'h5AEF_EE00, 2));

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], i);

    // Reset lands in the RMW_RD cycle of a byte store to word 3.
    wait_ready("rst_mid");
    drive(1'b1, SZ_BYTE, 1'b0, 32'h0C, 32'h77);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.rmw_read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid.read_gated", 32'(mem_read), 32'd0);
    chk("rst_mid.write_gated", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("rst_mid.ready_after", 32'(req_ready), 32'd1);
      if (mem_write || rsp_valid) extra++;
    end
    chk("rst_mid.no_activity", 32'(extra), 32'd0);
    chk("rst_mid.rdata_cleared", rsp_rdata, 32'h0);
    do_req(mk(0, SZ_WORD, 0, 32'h0C, 32'h0, 0, 32'h5AEF_EE00, 2), 100);

    // req_valid held high across an alternating load/store stream.
    s[0] = '{write: 1'b0, size: SZ_WORD, addr: 32'h14, wdata: 32'h0,         rdata: 32'h8899_AABB};
    s[1] = '{write: 1'b1, size: SZ_WORD, addr: 32'h28, wdata: 32'h0BAD_F00D, rdata: 32'h0};
    s[2] = '{write: 1'b0, size: SZ_WORD, addr: 32'h28, wdata: 32'h0,         rdata: 32'h0BAD_F00D};
    s[3] = '{write: 1'b1, size: SZ_BYTE, addr: 32'h29, wdata: 32'h33,        rdata: 32'h0};
    s[4] = '{write: 1'b0, size: SZ_WORD, addr: 32'h28, wdata: 32'h0,         rdata: 32'h0BAD_330D};
    wait_ready("stream");
    drive(s[0].write, s[0].size, 1'b0, s[0].addr, s[0].wdata);
    req_valid = 1'b1;
    acc_i = 0;
    rsp_i = 0;
    for (int c = 0; c < 60 && rsp_i < 5; c++) begin
      pend = req_ready && req_valid;
      @(negedge clk);
      if (pend) begin
        chk($sformatf("stream.busy%0d", acc_i), 32'(req_ready), 32'd0);
        acc_i++;
        if (acc_i < 5) drive(s[acc_i].write, s[acc_i].size, 1'b0, s[acc_i].addr, s[acc_i].wdata);
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        chk($sformatf("stream.order%0d", rsp_i), 32'(rsp_i < acc_i), 32'd1);
        chk($sformatf("stream.err%0d", rsp_i), 32'(rsp_err), 32'd0);
        if (!s[rsp_i].write) chk($sformatf("stream.rdata%0d", rsp_i), rsp_rdata, s[rsp_i].rdata);
        rsp_i++;
      end
    end
    req_valid = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    chk("stream.accepts", 32'(acc_i), 32'd5);
    chk("stream.responses", 32'(rsp_i), 32'd5);
    chk("stream.no_extra_rsp", 32'(extra), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM stage of the MIPS pipeline and the word-addressed data memory.
- Converts byte-addressed CPU load/store requests of byte, halfword or word size into word accesses on the data memory.
- Sub-word stores use a read-modify-write sequence, because the memory writes only whole 32-bit words.
- Performs lane extraction and sign/zero extension for loads, and flags misaligned, reserved-size or out-of-range accesses.

Parameters:
DEPTH, 2010, number of 32-bit words in the attached data memory; valid word indices are 0..DEPTH-1
ADDR_W, 32, width of the CPU byte address

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  unit idle and able to accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; the value sits right-aligned in the low bits
rsp_valid  out  1  one-cycle pulse on completion
rsp_err  out  1  valid with rsp_valid; access rejected, no memory side effect
rsp_rdata  out  32  load result; valid with rsp_valid; held until the next response
mem_address  out  32  word index to memory, equal to the latched byte address shifted right by 2
mem_writeData  out  32  word to write
mem_write  out  1  memory write enable; memory commits on posedge
mem_read  out  1  memory read enable
mem_readData  in  32  memory read data, combinational from mem_address

Behaviour:
- Reset values:
  - State is IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_write=0, mem_read=0, mem_address=0, mem_writeData=0.
- Reset gating: mem_write and mem_read are gated combinationally with ~rst, so no memory write commits on an edge where rst is high.
- A reset mid-sequence abandons the operation and produces no response.
- Acceptance: a request is accepted on a posedge where req_valid=1 and state=IDLE. Addr, size, signed, write and wdata are latched on that edge.
- While not IDLE, req_ready=0 and req_valid is ignored.
- Error check at acceptance, any of:
  - req_size=11
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr>>2 >= DEPTH
- On error: go to RESP with rsp_err=1. mem_read and mem_write stay 0 throughout.
- States and transitions:
  - IDLE -> LOAD (load) | STORE_W (word store) | RMW_RD (byte/half store) | RESP (error)
  - LOAD: mem_read=1. Extract the lane selected by addr[1:0], extend it, and register it into rsp_rdata. Next state is RESP.
  - STORE_W: mem_write=1, mem_writeData=wdata. Next state is RESP.
  - RMW_RD: mem_read=1. Register mem_readData into the merge register. Next state is RMW_WR.
  - RMW_WR: mem_write=1. mem_writeData is the merge register with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Next state is RESP.
  - RESP: rsp_valid=1 for exactly one cycle, rsp_err as computed. Next state is IDLE, so req_ready=1 in the following cycle.
- Latency: cycles from the accept edge to the rsp_valid cycle:
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
  - Error: 1.
- Throughput: at most one request in flight. Back-to-back requests are spaced by the latency + 1.
- Endianness: little-endian.
  - Byte lane k occupies bits [8k+7:8k].
  - The halfword at addr[1]=h occupies bits [16h+15:16h].
- mem_address is held constant from the first memory-access cycle through RMW_WR.
- Stores do not modify rsp_rdata. Loads with an error leave rsp_rdata unchanged.

Decomposition:
- Package lsu_pkg holds:
  - Size encoding constants: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
- Sub-module byte_lane_unit (purely combinational) provides:
  - Load extraction: word, offset, size and signed in; 32-bit result out.
  - Store merge: old word, wdata, offset and size in; merged word out.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Memory word 5 = 0x8899AABB. Load, byte, signed, addr 0x16 -> rsp_valid 2 cycles after accept, rsp_rdata=0xFFFFFF99, rsp_err=0.
- Same word. Load, half, unsigned, addr 0x16 -> rsp_rdata=0x00008899. Word load at addr 0x14 -> 0x8899AABB.
- Memory word 3 = 0x11223344. Store byte 0xEE to addr 0x0D -> mem_write high in exactly one cycle, 2 cycles after accept, with mem_writeData=0x1122EE44. rsp_valid at cycle 3. A subsequent word load returns 0x1122EE44.
- Misaligned half store at addr 0x0F, and word load at DEPTH*4 -> rsp_err=1 one cycle after accept. No mem_write or mem_read pulse. Memory is unchanged.
- rst asserted during the RMW_RD cycle of a byte store -> no mem_write ever, no rsp_valid, req_ready=1 the cycle after reset deasserts. The target word is unchanged.
- req_valid held high continuously with alternating load/store -> each request is accepted only when req_ready=1. Responses are in order, with no lost or duplicated rsp_valid pulses.
